debounce_scanner: RTL

Time-multiplexed debounce controller that services N switch inputs with one shared sample timebase and one shared compare/count datapath, instead of one free-running debouncer per switch. A round-robin channel pointer visits one channel per scan tick and updates that channel's stable state and stability counter. Per-channel level and edge-pulse outputs feed LED/toggle logic in the top-level design. The block sits between the board switch pins and the user logic.

---
 rtl/debounce_pkg.sv | 19 +
 rtl/debounce_scanner_if.sv | 34 +++
 rtl/scan_prescaler.sv | 33 +++
 rtl/debounce_scanner.sv | 99 +++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared constants and width helper for the time-multiplexed debounce scanner.
package debounce_pkg;

    localparam int unsigned DB_TICK_DIV   = 1000;
    localparam int unsigned DB_STABLE_CNT = 8;

    // Ceiling log2, never below 1 so a single-value range still gets a real bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                w = i + 1;
            end
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_scanner_if.sv
// Switch-side and user-side signal bundle of the debounce scanner.
interface debounce_scanner_if
    import debounce_pkg::*;
#(
    parameter int unsigned N = 4
);

    localparam int unsigned SW = clog2(N);

    logic [N-1:0]  switch_in;
    logic [N-1:0]  state;
    logic [N-1:0]  trans_up;
    logic [N-1:0]  trans_dn;
    logic [SW-1:0] scan_ch;

    // Environment side: drives the raw pins, consumes the debounced view.
    modport master (
        output switch_in,
        input  state,
        input  trans_up,
        input  trans_dn,
        input  scan_ch
    );

    // Scanner side.
    modport slave (
        input  switch_in,
        output state,
        output trans_up,
        output trans_dn,
        output scan_ch
    );

endinterface

// File: rtl/scan_prescaler.sv
// Free-running divider producing a one-cycle scan tick every TICK_DIV clocks.
module scan_prescaler
    import debounce_pkg::*;
#(
    parameter int unsigned TICK_DIV = DB_TICK_DIV
) (
    input  logic CLK,
    input  logic RST,
    output logic tick
);

    localparam int unsigned    PW   = clog2(TICK_DIV);
    localparam logic [PW-1:0]  LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]  ONE  = PW'(1);

    logic [PW-1:0] r_count;
    logic          w_last;

    assign w_last = (r_count == LAST);
    assign tick   = w_last;

    // Count 0..TICK_DIV-1 and wrap; tick is the terminal-count cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_count <= '0;
        end else if (w_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + ONE;
        end
    end

endmodule

// File: rtl/debounce_scanner.sv
// Round-robin debouncer: one shared compare/count datapath serves all channels,
// visiting one channel per scan tick.
module debounce_scanner
    import debounce_pkg::*;
#(
    parameter int unsigned N          = 4,
    parameter int unsigned TICK_DIV   = DB_TICK_DIV,
    parameter int unsigned STABLE_CNT = DB_STABLE_CNT
) (
    input  logic               CLK,
    input  logic               RST,
    debounce_scanner_if.slave  bus
);

    localparam int unsigned   SW        = clog2(N);
    localparam int unsigned   CW        = clog2(STABLE_CNT);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(STABLE_CNT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [SW-1:0] CH_LAST   = SW'(N - 1);
    localparam logic [SW-1:0] CH_ONE    = SW'(1);

    logic [N-1:0]  r_sync1;
    logic [N-1:0]  r_sync2;
    logic [N-1:0]  r_state;
    logic [N-1:0]  r_up;
    logic [N-1:0]  r_dn;
    logic [SW-1:0] r_scan_ch;
    logic [CW-1:0] r_cnt [N];

    logic          w_tick;
    logic          w_sample;
    logic          w_cur;
    logic          w_disagree;
    logic          w_at_limit;
    logic [CW-1:0] w_cnt_cur;
    logic [SW-1:0] w_scan_next;

    scan_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .CLK  (CLK),
        .RST  (RST),
        .tick (w_tick)
    );

    // The single shared datapath: select the visited channel, compare, test limit.
    assign w_sample    = r_sync2[r_scan_ch];
    assign w_cur       = r_state[r_scan_ch];
    assign w_cnt_cur   = r_cnt[r_scan_ch];
    assign w_disagree  = w_sample ^ w_cur;
    assign w_at_limit  = (w_cnt_cur == CNT_LIMIT);
    assign w_scan_next = (r_scan_ch == CH_LAST) ? '0 : (r_scan_ch + CH_ONE);

    // Two-flop synchronizer on every raw switch pin.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.switch_in;
            r_sync2 <= r_sync1;
        end
    end

    // Per-tick update of the visited channel; pulses live for one cycle only.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= '0;
            r_up      <= '0;
            r_dn      <= '0;
            r_scan_ch <= '0;
            for (int i = 0; i < int'(N); i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_up <= '0;
            r_dn <= '0;
            if (w_tick) begin
                if (!w_disagree) begin
                    r_cnt[r_scan_ch] <= '0;
                end else if (!w_at_limit) begin
                    r_cnt[r_scan_ch] <= w_cnt_cur + CNT_ONE;
                end else begin
                    r_cnt[r_scan_ch]   <= '0;
                    r_state[r_scan_ch] <= w_sample;
                    r_up[r_scan_ch]    <= w_sample;
                    r_dn[r_scan_ch]    <= ~w_sample;
                end
                r_scan_ch <= w_scan_next;
            end
        end
    end

    assign bus.state    = r_state;
    assign bus.trans_up = r_up;
    assign bus.trans_dn = r_dn;
    assign bus.scan_ch  = r_scan_ch;

endmodule
